bram_stream_reader: RTL and testbench

//  Read-side initiator for the dual-port bram: on a start command, fetches a contiguous

---
 rtl/bram_stream_reader.sv | 139 +++++++++++++
 tb/tb_bram_stream_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: fetches a contiguous block of bram words and streams it out over valid/ready.
// Define BRAM_RD_ABORT_EN to add the abort input.
module bram_stream_reader #(
  parameter int RAM_WIDTH    = 36,
  parameter int RAM_DEPTH    = 512,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4,
  localparam int ADDR_W      = $clog2(RAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      length,
`ifdef BRAM_RD_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic                 ram_we,
  output logic                 ram_rst,
  input  logic [RAM_WIDTH-1:0] ram_dout,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last
);
  localparam int RL = READ_LATENCY;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < READ_LATENCY + 1) begin : g_depth_chk
    $error("FIFO_DEPTH must be >= READ_LATENCY+1");
  end

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, FIN, ABRT} state_t;
  state_t state, nxt;
  logic [ADDR_W:0] len_q, cnt, cnt_n, len_n;
  logic [ADDR_W-1:0] addr_n;
  logic [RL:0] pipe_v, pipe_l;
  logic [RAM_WIDTH-1:0] fifo_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_l;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0] used;
  logic abort_go, issue, last_issue, wr, pop, fifo_ne;

`ifdef BRAM_RD_ABORT_EN
  assign abort_go = abort && (state == RUN || state == DRAIN);
`else
  assign abort_go = 1'b0;
`endif

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(FIFO_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  // Credit counts every read still in the pipe, so a granted issue always finds a FIFO slot.
  always_comb begin
    used = (CW + 1)'(fifo_cnt);
    for (int i = 0; i <= RL; i++) used = used + (CW + 1)'(pipe_v[i]);
  end

  // The first address goes out on the accepting edge itself to save a cycle of latency.
  assign cnt_n      = (state == IDLE ? '0 : cnt) + (ADDR_W + 1)'(1);
  assign len_n      = state == IDLE ? length : len_q;
  assign addr_n     = state == IDLE ? base_addr :
                      ram_addr == ADDR_W'(RAM_DEPTH - 1) ? '0 : ram_addr + ADDR_W'(1);
  assign issue      = (state == IDLE && start && length != '0) ||
                      (state == RUN && used < (CW + 1)'(FIFO_DEPTH) && !abort_go);
  assign last_issue = issue && cnt_n == len_n;

  // Reads retiring during an abort are dropped; an empty FIFO forwards the bram word directly.
  assign wr      = pipe_v[RL] && state != ABRT;
  assign fifo_ne = fifo_cnt != '0;
  assign m_valid = fifo_ne || wr;
  assign m_data  = fifo_ne ? fifo_d[rd_ptr] : ram_dout;
  assign m_last  = fifo_ne ? fifo_l[rd_ptr] : wr && pipe_l[RL];
  assign pop     = m_valid && m_ready;
  assign ram_we  = 1'b0;
  assign ram_rst = 1'b0;

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !start ? IDLE : length == '0 ? FIN : last_issue ? DRAIN : RUN;
      RUN:     nxt = abort_go ? ABRT : last_issue ? DRAIN : RUN;
      DRAIN:   nxt = abort_go ? ABRT : pop && m_last ? FIN : DRAIN;
      ABRT:    nxt = pipe_v[RL-1:0] == '0 ? FIN : ABRT;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = state != IDLE;
    done = state == FIN;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q    <= '0;
      cnt      <= '0;
      ram_addr <= '0;
      pipe_v   <= '0;
      pipe_l   <= '0;
    end else begin
      pipe_v <= {pipe_v[RL-1:0], issue};
      pipe_l <= {pipe_l[RL-1:0], last_issue};
      if (state == IDLE && start) len_q <= length;
      if (issue) begin
        cnt      <= cnt_n;
        ram_addr <= addr_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn || abort_go) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr) wr_ptr <= inc(wr_ptr);
      if (pop) rd_ptr <= inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CW'(wr) - CW'(pop);
    end
  end

  always_ff @(posedge clk)
    if (wr) begin
      fifo_d[wr_ptr] <= ram_dout;
      fifo_l[wr_ptr] <= pipe_l[RL];
    end
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: directed and random commands against a queue model of the expected stream.
module tb_bram_stream_reader;
  localparam int W = 36, D = 512, AW = 9, RL = 2;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, m_ready = 1'b0;
  logic busy, done, ram_we, ram_rst, m_valid, m_last;
  logic [AW-1:0] base_addr = '0, ram_addr;
  logic [AW:0] length = '0;
  logic [W-1:0] ram_dout, m_data, r1, r2;
  logic [W-1:0] mem [D];
`ifdef BRAM_RD_ABORT_EN
  logic abort = 1'b0, pend_abort = 1'b0;
`endif

  always #5 clk = ~clk;

  // Two-register bram read path: dout follows addr after READ_LATENCY edges
  always @(posedge clk) begin
    r1 <= mem[ram_addr];
    r2 <= r1;
  end
  assign ram_dout = r2;

  bram_stream_reader dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .length(length),
`ifdef BRAM_RD_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_we(ram_we), .ram_rst(ram_rst),
    .ram_dout(ram_dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  int vecs = 0, errs = 0;
  int cyc_idx, first_valid, done_at, beats, hold = 0, rdy_mode = 0, ka, b, n;
  logic [W-1:0] exp_q [$];
  logic pend_start = 1'b0, tog = 1'b0, prev_stall = 1'b0, saw_last = 1'b0;
  logic [W:0] prev_word;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_mem(input bit addr_eq);
    for (int i = 0; i < D; i++) mem[i] = addr_eq ? W'(i) : W'({$urandom(), $urandom()});
  endtask

  // One clock: drive at negedge, sample settled outputs, score any handshake on the next posedge
  task automatic cycle();
    @(negedge clk);
    start = pend_start;
    pend_start = 1'b0;
`ifdef BRAM_RD_ABORT_EN
    abort = pend_abort;
    pend_abort = 1'b0;
`endif
    tog = ~tog;
    m_ready = hold > 0 ? 1'b0 : rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? tog : 1'($urandom_range(0, 1));
    if (hold > 0) hold--;
    #1;
    if (prev_stall) begin
      chk("stall_valid", 64'(m_valid), 64'(1));
      chk("stall_word", 64'({m_last, m_data}), 64'(prev_word));
    end
    if (m_valid && first_valid < 0) first_valid = cyc_idx;
    if (done && done_at < 0) done_at = cyc_idx;
    if (m_last) saw_last = 1'b1;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("extra_beat", 64'(m_valid), 64'(0));
      else begin
        chk("beat_data", 64'(m_data), 64'(exp_q[0]));
        chk("beat_last", 64'(m_last), 64'(exp_q.size() == 1));
        void'(exp_q.pop_front());
        beats++;
      end
    end
    prev_stall = m_valid && !m_ready;
    prev_word = {m_last, m_data};
    cyc_idx++;
  endtask

  task automatic issue(input int bb, input int nn);
    base_addr = AW'(bb);
    length = (AW + 1)'(nn);
    pend_start = 1'b1;
    for (int k = 0; k < nn; k++) exp_q.push_back(mem[(bb + k) % D]);
    cyc_idx = 0;
    first_valid = -1;
    done_at = -1;
    beats = 0;
    saw_last = 1'b0;
  endtask

  task automatic run_to_done(input int cap);
    for (int i = 0; i < cap && done_at < 0; i++) cycle();
    chk("done_seen", 64'(done_at >= 0), 64'(1));
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  initial begin
    set_mem(1'b1);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_valid", 64'(m_valid), 64'(0));
    chk("rst_last", 64'(m_last), 64'(0));
    chk("rst_addr", 64'(ram_addr), 64'(0));
    chk("ram_we", 64'(ram_we), 64'(0));
    chk("ram_rst", 64'(ram_rst), 64'(0));
    @(negedge clk);
    rstn = 1'b1;

    issue(16, 8);
    run_to_done(40);
    chk("t1_first_valid", 64'(first_valid), 64'(RL + 1));
    chk("t1_done_at", 64'(done_at), 64'(11));
    chk("t1_beats", 64'(beats), 64'(8));
    cycle();
    chk("t1_done_pulse", 64'(done), 64'(0));
    chk("t1_busy_low", 64'(busy), 64'(0));

    issue(32'h1FE, 4);
    run_to_done(40);
    chk("t2_beats", 64'(beats), 64'(4));

    rdy_mode = 1;
    issue(int'($urandom_range(0, D - 1)), 16);
    repeat (6) cycle();
    hold = 10;
    run_to_done(200);
    chk("t3_beats", 64'(beats), 64'(16));
    rdy_mode = 0;

    issue(5, 0);
    run_to_done(10);
    chk("t4_done_at", 64'(done_at), 64'(1));
    chk("t4_no_valid", 64'(first_valid), 64'(-1));
    cycle();
    chk("t4_done_pulse", 64'(done), 64'(0));
    issue(300, 6);
    cycle();
    cycle();
    chk("t4_busy", 64'(busy), 64'(1));
    base_addr = AW'(100);
    length = (AW + 1)'(3);
    pend_start = 1'b1;
    run_to_done(60);
    chk("t4_beats", 64'(beats), 64'(6));
    repeat (4) cycle();
    chk("t4_ignored_start", 64'(busy), 64'(0));

    issue(int'($urandom_range(0, D - 1)), 32);
    for (int i = 0; i < 40 && beats < 5; i++) cycle();
    chk("t5_beats_pre", 64'(beats), 64'(5));
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_done", 64'(done), 64'(0));
    chk("t5_valid", 64'(m_valid), 64'(0));
    chk("t5_last", 64'(m_last), 64'(0));
    chk("t5_addr", 64'(ram_addr), 64'(0));
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    issue(0, 2);
    run_to_done(30);
    chk("t5_beats_post", 64'(beats), 64'(2));
    cycle();
    chk("t5_idle", 64'(busy), 64'(0));

    rdy_mode = 2;
    for (int t = 0; t < 7; t++) begin
      set_mem(1'b0);
      b = int'($urandom_range(0, D - 1));
      n = t == 6 ? D : int'($urandom_range(1, 48));
      issue(b, n);
      run_to_done(6 * n + 40);
      chk("rnd_beats", 64'(beats), 64'(n));
    end
    rdy_mode = 0;

`ifdef BRAM_RD_ABORT_EN
    issue(int'($urandom_range(0, D - 1)), 20);
    for (int i = 0; i < 40 && beats < 3; i++) cycle();
    pend_abort = 1'b1;
    ka = cyc_idx;
    cycle();
    cycle();
    chk("t6_valid_drop", 64'(m_valid), 64'(0));
    for (int i = 0; i < RL + 1 && done_at < 0; i++) cycle();
    chk("t6_done_in_time", 64'(done_at >= 0 && done_at - ka <= RL + 2), 64'(1));
    chk("t6_no_last", 64'(saw_last), 64'(0));
    exp_q.delete();
    cycle();
    chk("t6_busy_low", 64'(busy), 64'(0));
    pend_abort = 1'b1;
    cycle();
    cycle();
    chk("t6_idle_abort", 64'(busy | done), 64'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
